// File: rtl/axis_capture_pkg.sv
// Shared types and register map for the AXI-Stream capture block.
// Used by axis_capture_blockram and its bench.
package axis_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE,
    DRAIN
  } cap_state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 0;
  localparam int REG_LENGTH = 1;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;

  localparam int ST_CAPTURING = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_OVERFLOW  = 2;

  function automatic logic [2:0] pack_status(
    input logic capturing,
    input logic done,
    input logic overflow
  );
    logic [2:0] s;
    s               = '0;
    s[ST_CAPTURING] = capturing;
    s[ST_DONE]      = done;
    s[ST_OVERFLOW]  = overflow;
    return s;
  endfunction

endpackage

// File: rtl/axis_capture_blockram_ram.sv
// Simple dual-port block RAM: one write port, one registered
// read-first read port.
module blockram_sdp #(
  parameter int G_WIDTH = 32,
  parameter int G_DEPTH = 1024,
  parameter int G_AW    = $clog2(G_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [G_AW-1:0]    waddr,
  input  logic [G_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [G_AW-1:0]    raddr,
  output logic [G_WIDTH-1:0] rdata
);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [G_WIDTH-1:0] rdata_q;

  // Non-blocking read of mem_q gives old data on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_capture_blockram.sv
// Captures one AXI-Stream frame into block RAM, readable via a memory port.
// Define AXIS_CAPTURE_DROP_EN to drain the rest of an overflowed frame.
module axis_capture_blockram
  import axis_capture_pkg::*;
#(
  parameter int G_AXI_DATAWIDTH  = 32,
  parameter int G_AXIS_DATAWIDTH = 32,
  parameter int G_MEMDEPTH       = 1024,
  parameter int G_ADDRWIDTH      = $clog2(G_MEMDEPTH),
  parameter int G_WSTRB          = ((G_AXI_DATAWIDTH-1)/8)+1
) (
  input  logic                        s_aclk,
  input  logic                        s_aresetn,
  input  logic [G_AXIS_DATAWIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  input  logic                        rd,
  input  logic [G_ADDRWIDTH:0]        raddr,
  output logic [G_AXI_DATAWIDTH-1:0]  rdata,
  output logic                        rvalid,
  input  logic                        wr,
  input  logic [G_ADDRWIDTH:0]        waddr,
  input  logic [G_AXI_DATAWIDTH-1:0]  wdata,
  input  logic [G_WSTRB-1:0]          wstrb,
  output logic                        frame_done
);

  localparam int AW = G_ADDRWIDTH;

  cap_state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0] length_q, length_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic tready_q, tready_d;
  logic frame_done_q, frame_done_d;
  logic rvalid_q, rvalid_d;
  logic sel_ram_q, sel_ram_d;
  logic [G_AXI_DATAWIDTH-1:0] reg_rdata_q, reg_rdata_d;

  logic accept;
  logic ctrl_wr;
  logic arm;
  logic abort;
  logic ram_we;
  logic ram_re;
  logic [2:0] status;
  logic [AW-1:0] roff;
  logic [G_AXIS_DATAWIDTH-1:0] ram_rdata;
  logic unused;

  assign accept = s_axis_tvalid & tready_q;
  assign ctrl_wr = wr & waddr[AW] & wstrb[0]
                 & (waddr[AW-1:0] == AW'(REG_CTRL));
  assign abort = ctrl_wr & wdata[CTRL_ABORT];
  assign arm = ctrl_wr & wdata[CTRL_ARM] & ~abort;
  assign ram_we = accept & (state_q == CAPTURE);
  assign ram_re = rd & ~raddr[AW];
  assign roff = raddr[AW-1:0];
  assign status = pack_status(state_q == CAPTURE, done_q, ovf_q);
  assign unused = ^{wstrb, wdata, waddr};

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    length_d = length_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      CAPTURE: begin
        if (accept) begin
          wptr_d   = wptr_q + 1'b1;
          length_d = length_q + 1'b1;
          if (s_axis_tlast) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (wptr_q == AW'(G_MEMDEPTH-1)) begin
            ovf_d = 1'b1;
`ifdef AXIS_CAPTURE_DROP_EN
            state_d = DRAIN;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
      DRAIN: begin
        if (accept && s_axis_tlast) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // A re-arm discards any beat counted this cycle.
    if (arm) begin
      state_d  = CAPTURE;
      wptr_d   = '0;
      length_d = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end
    if (abort) begin
      state_d = IDLE;
    end
    tready_d = (state_d == CAPTURE) || (state_d == DRAIN);
    frame_done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_comb begin
    rvalid_d    = rd;
    sel_ram_d   = ram_re;
    reg_rdata_d = '0;
    unique case (1'b1)
      (roff == AW'(REG_STATUS)):
        reg_rdata_d = G_AXI_DATAWIDTH'(status);
      (roff == AW'(REG_LENGTH)):
        reg_rdata_d = G_AXI_DATAWIDTH'(length_q);
      default: ;
    endcase
  end

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      length_q     <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      rvalid_q     <= 1'b0;
      sel_ram_q    <= 1'b0;
      reg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      length_q     <= length_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      tready_q     <= tready_d;
      frame_done_q <= frame_done_d;
      rvalid_q     <= rvalid_d;
      sel_ram_q    <= sel_ram_d;
      reg_rdata_q  <= reg_rdata_d;
    end
  end

  blockram_sdp #(
    .G_WIDTH (G_AXIS_DATAWIDTH),
    .G_DEPTH (G_MEMDEPTH),
    .G_AW    (AW)
  ) u_ram (
    .clk   (s_aclk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (s_axis_tdata),
    .re    (ram_re),
    .raddr (roff),
    .rdata (ram_rdata)
  );

  // RAM output register has no reset, so gate it until a read returns.
  assign rdata = !rvalid_q ? '0
               : sel_ram_q ? G_AXI_DATAWIDTH'(ram_rdata)
               : reg_rdata_q;
  assign rvalid = rvalid_q;
  assign s_axis_tready = tready_q;
  assign frame_done = frame_done_q;

endmodule
